// File: rtl/bcd_to_binary_converter.sv
// bcd_to_binary_converter: 3-digit BCD to N-bit binary by reverse double-dabble.
// Each bit shifts {BCD,BIN} right by one, then subtracts 3 from every BCD digit >= 8.
// Optional macro BCD2BIN_SINGLE_CYCLE_EN merges shift and adjust into one ITER state per bit.
// Ports: clk/rst (sync, active-high), convierte start (sampled in IDLE only),
//        Centenas/Decenas/Unidades BCD digits (sampled in LOAD only),
//        OUT registered result, error registered invalid-digit flag,
//        listo = idle decode, fin = one-cycle done decode.
module bcd_to_binary_converter #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         convierte,
  input  logic [3:0]   Centenas,
  input  logic [3:0]   Decenas,
  input  logic [3:0]   Unidades,
  output logic [N-1:0] OUT,
  output logic         error,
  output logic         listo,
  output logic         fin
);

  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SHIFT  = 3'd2,
    S_ADJUST = 3'd3,
    S_DONE   = 3'd4,
    S_ITER   = 3'd5
  } state_t;

  state_t        r_state;
  logic [11:0]   r_bcd;
  logic [N-1:0]  r_bin;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_out;
  logic          r_error;

  logic [11:0]   w_shift_bcd;
  logic [N-1:0]  w_shift_bin;
  logic          w_bad_digit;

  // Per-digit correction; 4-bit arithmetic so no borrow crosses digits.
  function automatic logic [11:0] adjust_digits(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      if (b[i*4 +: 4] >= 4'd8) r[i*4 +: 4] = b[i*4 +: 4] - 4'd3;
      else                     r[i*4 +: 4] = b[i*4 +: 4];
    end
    return r;
  endfunction

  // BCD bit 0 falls into the top of BIN; a zero enters the top of BCD.
  assign w_shift_bcd = {1'b0, r_bcd[11:1]};
  assign w_shift_bin = {r_bcd[0], r_bin[N-1:1]};

  assign w_bad_digit = (Centenas > 4'd9) || (Decenas > 4'd9) || (Unidades > 4'd9);

  assign listo = (r_state == S_IDLE);
  assign fin   = (r_state == S_DONE);
  assign OUT   = r_out;
  assign error = r_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_bcd   <= '0;
      r_bin   <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (convierte) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_bcd <= {Centenas, Decenas, Unidades};
          r_bin <= '0;
          r_cnt <= CW'(N - 1);
          if (w_bad_digit) begin
            r_error <= 1'b1;
            r_out   <= '0;
            r_state <= S_DONE;
          end else begin
            r_error <= 1'b0;
`ifdef BCD2BIN_SINGLE_CYCLE_EN
            r_state <= S_ITER;
`else
            r_state <= S_SHIFT;
`endif
          end
        end
`ifdef BCD2BIN_SINGLE_CYCLE_EN
        S_ITER: begin
          r_bcd <= adjust_digits(w_shift_bcd);
          r_bin <= w_shift_bin;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_out   <= w_shift_bin;
            r_state <= S_DONE;
          end
        end
`else
        S_SHIFT: begin
          r_bcd   <= w_shift_bcd;
          r_bin   <= w_shift_bin;
          r_state <= S_ADJUST;
        end
        S_ADJUST: begin
          r_bcd <= adjust_digits(r_bcd);
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_out   <= r_bin;
            r_state <= S_DONE;
          end else begin
            r_state <= S_SHIFT;
          end
        end
`endif
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_converter.sv
// Directed, table-driven bench for bcd_to_binary_converter plus hand-written
// sequences for mid-conversion reset and back-to-back conversions.
module tb_bcd_to_binary_converter;

  localparam int N = 10;
`ifdef BCD2BIN_SINGLE_CYCLE_EN
  localparam int LAT = N + 1;
`else
  localparam int LAT = 2 * N + 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         convierte;
  logic [3:0]   Centenas, Decenas, Unidades;
  logic [N-1:0] OUT;
  logic         error, listo, fin;

  int checks   = 0;
  int failures = 0;

  bcd_to_binary_converter #(.N(N)) dut (
    .clk(clk), .rst(rst), .convierte(convierte),
    .Centenas(Centenas), .Decenas(Decenas), .Unidades(Unidades),
    .OUT(OUT), .error(error), .listo(listo), .fin(fin)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  c, d, u;
    logic [15:0] exp_out;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Wait for fin; returns edge index (after E0) where fin is first seen, or -1.
  // Scrambles the digit inputs after E1 to prove they are only sampled in LOAD.
  task automatic wait_fin(input logic scramble, input logic [N-1:0] out_before,
                          output int k);
    logic out_stable = 1'b1;
    k = -1;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk); #1;
      if (fin) begin k = e; break; end
      if (OUT !== out_before) out_stable = 1'b0;
      if (scramble && e == 1) begin
        Centenas = 4'(e + 6); Decenas = 4'hF; Unidades = 4'd7;
      end
    end
    check("out_stable_midconv", int'(out_stable), 1);
    if (k < 0) check("fin_timeout", 0, 1);
  endtask

  task automatic convert(input vec_t v, input string name);
    int k;
    logic [N-1:0] prev;
    @(negedge clk);
    Centenas = v.c; Decenas = v.d; Unidades = v.u; convierte = 1'b1;
    prev = OUT;
    @(posedge clk); #1;              // E0
    convierte = 1'b0;
    check({name, "_listo_busy"}, int'(listo), 0);
    wait_fin(1'b1, prev, k);
    check({name, "_latency"}, k, v.exp_err ? 1 : LAT);
    check({name, "_out"}, int'(OUT), int'(v.exp_out));
    check({name, "_err"}, int'(error), int'(v.exp_err));
    @(posedge clk); #1;
    check({name, "_fin_one_cycle"}, int'(fin), 0);
    check({name, "_listo_back"}, int'(listo), 1);
  endtask

  initial begin
    int k1, k2;
    vecs[0]  = '{4'd9, 4'd9, 4'd9, 16'd999, 1'b0};
    vecs[1]  = '{4'd0, 4'd0, 4'd0, 16'd0,   1'b0};
    vecs[2]  = '{4'd5, 4'd1, 4'd2, 16'd512, 1'b0};
    vecs[3]  = '{4'd1, 4'd2, 4'd8, 16'd128, 1'b0};
    vecs[4]  = '{4'd4, 4'hA, 4'd3, 16'd0,   1'b1};
    vecs[5]  = '{4'd0, 4'd4, 4'd2, 16'd42,  1'b0};
    vecs[6]  = '{4'd0, 4'd0, 4'd9, 16'd9,   1'b0};
    vecs[7]  = '{4'hA, 4'd0, 4'd0, 16'd0,   1'b1};
    vecs[8]  = '{4'd0, 4'd9, 4'd0, 16'd90,  1'b0};
    vecs[9]  = '{4'd3, 4'd3, 4'hF, 16'd0,   1'b1};
    vecs[10] = '{4'd9, 4'd0, 4'd0, 16'd900, 1'b0};
    vecs[11] = '{4'd6, 4'd7, 4'd5, 16'd675, 1'b0};

    rst = 1'b1; convierte = 1'b0;
    Centenas = 4'd0; Decenas = 4'd0; Unidades = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out",   int'(OUT),   0);
    check("rst_error", int'(error), 0);
    check("rst_listo", int'(listo), 1);
    check("rst_fin",   int'(fin),   0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) convert(vecs[i], $sformatf("vec%0d", i));

    // Reset at E7 aborts a 999 conversion.
    @(negedge clk);
    Centenas = 4'd9; Decenas = 4'd9; Unidades = 4'd9; convierte = 1'b1;
    @(posedge clk); #1; convierte = 1'b0;      // E0
    begin
      logic saw_fin = 1'b0;
      for (int e = 1; e <= 6; e++) begin
        @(posedge clk); #1;
        if (fin) saw_fin = 1'b1;
      end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;                     // E7
      check("abort_listo", int'(listo), 1);
      check("abort_out",   int'(OUT),   0);
      @(negedge clk); rst = 1'b0;
      for (int e = 0; e < LAT + 4; e++) begin
        @(posedge clk); #1;
        if (fin) saw_fin = 1'b1;
      end
      check("abort_no_fin", int'(saw_fin), 0);
      check("abort_idle",   int'(listo),   1);
    end
    convert('{4'd2, 4'd5, 4'd5, 16'd255, 1'b0}, "after_abort");

    // convierte held high: 123 then 321, digits swapped while busy.
    @(negedge clk);
    Centenas = 4'd1; Decenas = 4'd2; Unidades = 4'd3; convierte = 1'b1;
    @(posedge clk); #1;                       // E0 of first
    k1 = -1;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin Centenas = 4'd3; Decenas = 4'd2; Unidades = 4'd1; end
      if (fin) begin k1 = e; break; end
    end
    check("b2b_first_lat", k1, LAT);
    check("b2b_first_out", int'(OUT), 123);
    k2 = -1;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk); #1;
      if (e == 1) check("b2b_idle_gap", int'(listo), 1);
      if (e == 3) begin Centenas = 4'd9; Decenas = 4'd9; Unidades = 4'd9; end
      if (fin) begin k2 = e; break; end
    end
    convierte = 1'b0;
    check("b2b_fin_gap", k2, LAT + 2);
    check("b2b_second_out", int'(OUT), 321);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b_stays_idle", int'(listo), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
